// File: rtl/fp_divider_pkg.sv
// -----------------------------------------------------------------------------
// fp_divider_pkg
// Shared FP definitions used by the divider (and by the multiplier that sits
// next to it): the single-precision fp struct, the SpecialCases result
// classification, and the divider's constants and FSM state type.
// -----------------------------------------------------------------------------
package fp_divider_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp;

    typedef enum logic [2:0] {
        zero              = 3'd0,
        normalizedNumber  = 3'd1,
        positive_infinity = 3'd2,
        negative_infinity = 3'd3,
        nan               = 3'd4,
        overflow          = 3'd5,
        underflow         = 3'd6
    } SpecialCases;

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam int          EXP_BIAS  = 127;
    localparam int          QUOT_BITS = 26;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, 8'hFF, 23'h0};
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'h0};
    endfunction

endpackage

// File: rtl/fp_divider_mant_iter.sv
// -----------------------------------------------------------------------------
// fp_divider_mant_iter
// Combinational restoring-division step(s). Produces ITER_PER_CYCLE quotient
// bits, MSB first, from the current partial remainder and the divisor.
//
// Ports:
//   rem_i     partial remainder to compare this cycle (always < 2*divisor)
//   divisor_i {1, b.mantissa}
//   rem_o     partial remainder for the next cycle (already shifted left)
//   qbits_o   quotient bits, qbits_o[ITER_PER_CYCLE-1] is the first produced
// -----------------------------------------------------------------------------
module fp_divider_mant_iter #(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic [24:0]               rem_i,
    input  logic [23:0]               divisor_i,
    output logic [24:0]               rem_o,
    output logic [ITER_PER_CYCLE-1:0] qbits_o
);

    logic [24:0] r;

    always_comb begin
        r       = rem_i;
        qbits_o = '0;
        for (int i = ITER_PER_CYCLE - 1; i >= 0; i--) begin
            if (r >= {1'b0, divisor_i}) begin
                qbits_o[i] = 1'b1;
                r          = r - {1'b0, divisor_i};
            end
            // After a restore/subtract r < divisor < 2^24, so the shift is lossless.
            r = {r[23:0], 1'b0};
        end
        rem_o = r;
    end

endmodule

// File: rtl/fp_divider.sv
// -----------------------------------------------------------------------------
// fp_divider
// Iterative IEEE-754 single-precision divider, result = a / b, radix-2
// restoring mantissa division. Subnormal inputs are flushed to zero.
// Special operands finish one cycle after accept; normal operands spend
// 26/ITER_PER_CYCLE cycles in DIV and one in ROUND.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and result/status/div_by_zero hold until out_valid & out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake, a = dividend, b = divisor
//   out_valid / out_ready result handshake
//   result, status        quotient and its SpecialCases classification
//   div_by_zero           finite non-zero a divided by zero b
//   dbg_state             current FSM state (div_state_e encoding)
//
// Optional: define FP_DIV_ASSERT_EN to compile in protocol/datapath SVA.
// -----------------------------------------------------------------------------
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  status,
    output logic        div_by_zero,
    output logic [1:0]  dbg_state
);

    localparam int DIV_CYCLES = QUOT_BITS / ITER_PER_CYCLE;

    if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2) begin : g_bad_iter
        $error("fp_divider: ITER_PER_CYCLE must be 1 or 2");
    end

    fp a_fp, b_fp;
    assign a_fp = a;
    assign b_fp = b;

    div_state_e          state_q, state_d;
    logic                sign_q, sign_d;
    logic [9:0]          exp_base_q, exp_base_d;
    logic [24:0]         rem_q, rem_d;
    logic [23:0]         dvsr_q, dvsr_d;
    logic [QUOT_BITS-1:0] quot_q, quot_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         result_q, result_d;
    SpecialCases         status_q, status_d;
    logic                dbz_q, dbz_d;

    logic [24:0]               rem_nxt;
    logic [ITER_PER_CYCLE-1:0] qbits;

    fp_divider_mant_iter #(.ITER_PER_CYCLE(ITER_PER_CYCLE)) u_iter (
        .rem_i     (rem_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_nxt),
        .qbits_o   (qbits)
    );

    // Operand classification (exponent 0 means zero: no subnormals).
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, op_sign;
    assign a_zero  = (a_fp.exponent == 8'h00);
    assign b_zero  = (b_fp.exponent == 8'h00);
    assign a_inf   = (a_fp.exponent == 8'hFF) && (a_fp.mantissa == '0);
    assign b_inf   = (b_fp.exponent == 8'hFF) && (b_fp.mantissa == '0);
    assign a_nan   = (a_fp.exponent == 8'hFF) && (a_fp.mantissa != '0);
    assign b_nan   = (b_fp.exponent == 8'hFF) && (b_fp.mantissa != '0);
    assign op_sign = a_fp.sign ^ b_fp.sign;

    // Rounding of the finished quotient. q[25]=0 means the mantissa ratio
    // was below 1, so one more quotient bit is usable and the exponent drops.
    logic [22:0]       mant_raw;
    logic              guard, sticky, e_adj, round_up;
    logic [23:0]       mant_inc;
    logic signed [9:0] e_fin;

    always_comb begin
        if (quot_q[25]) begin
            mant_raw = quot_q[24:2];
            guard    = quot_q[1];
            sticky   = quot_q[0] | (rem_q != '0);
            e_adj    = 1'b0;
        end else begin
            mant_raw = quot_q[23:1];
            guard    = quot_q[0];
            sticky   = (rem_q != '0);
            e_adj    = 1'b1;
        end
        round_up = guard & (sticky | mant_raw[0]);
        mant_inc = {1'b0, mant_raw} + {23'b0, round_up};
        // mant_inc[23] is the carry-out: mantissa wraps to 0, exponent +1.
        e_fin    = $signed(exp_base_q) - $signed({9'b0, e_adj})
                 + $signed({9'b0, mant_inc[23]});
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_base_d = exp_base_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        status_d   = status_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d     = op_sign;
                    dbz_d      = 1'b0;
                    rem_d      = {1'b0, 1'b1, a_fp.mantissa};
                    dvsr_d     = {1'b1, b_fp.mantissa};
                    quot_d     = '0;
                    cnt_d      = '0;
                    exp_base_d = {2'b0, a_fp.exponent} - {2'b0, b_fp.exponent}
                               + 10'(EXP_BIAS);
                    state_d    = S_DONE;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result_d = QNAN;
                        status_d = nan;
                    end else if (a_inf) begin
                        result_d = signed_inf(op_sign);
                        status_d = op_sign ? negative_infinity : positive_infinity;
                    end else if (b_zero) begin
                        result_d = signed_inf(op_sign);
                        status_d = op_sign ? negative_infinity : positive_infinity;
                        dbz_d    = 1'b1;
                    end else if (a_zero || b_inf) begin
                        result_d = signed_zero(op_sign);
                        status_d = zero;
                    end else begin
                        state_d  = S_DIV;
                    end
                end
            end
            S_DIV: begin
                rem_d  = rem_nxt;
                quot_d = {quot_q[QUOT_BITS-1-ITER_PER_CYCLE:0], qbits};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (e_fin >= 10'sd255) begin
                    result_d = signed_inf(sign_q);
                    status_d = overflow;
                end else if (e_fin <= 10'sd0) begin
                    result_d = signed_zero(sign_q);
                    status_d = underflow;
                end else begin
                    result_d = {sign_q, e_fin[7:0], mant_inc[22:0]};
                    status_d = normalizedNumber;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            exp_base_q <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            status_q   <= zero;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_base_q <= exp_base_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            status_q   <= status_d;
            dbz_q      <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign status      = status_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

`ifdef FP_DIV_ASSERT_EN
    a_known_inputs: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown({a, b}))
        else $error("fp_divider: a/b unknown while in_valid");

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid))
        else $error("fp_divider: in_ready and out_valid both high");

    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(result) && $stable(status)))
        else $error("fp_divider: result/status changed under backpressure");

    a_norm_exp: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_ROUND && status_d == normalizedNumber)
            |-> (result_d[30:23] != 8'h00 && result_d[30:23] != 8'hFF))
        else $error("fp_divider: normal result exponent out of range");

    a_div_len: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(state_q == S_DIV)
            |-> (state_q == S_DIV) [*DIV_CYCLES] ##1 (state_q == S_ROUND))
        else $error("fp_divider: DIV phase length wrong");
`endif

endmodule
